// File: rtl/drum_column_engine.sv
// drum_column_engine: finite-difference drum column with its own u / u_prev
// memories, pyramid initial load, one node per 4 clocks and a centre tap.
module drum_column_engine #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 9,
  parameter int COLUMN_SIZE = 30,
  parameter logic [DATA_W-1:0] INIT_STEP = 18'h01111
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              init,
  input  logic              start,
  input  logic [DATA_W-1:0] rho,
  input  logic [3:0]        eta_shift,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] center_node
);

  localparam int PW = 2*DATA_W + 6;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(COLUMN_SIZE - 1);
  localparam logic [ADDR_W-1:0] TOP =
    ADDR_W'(COLUMN_SIZE - 2);
  localparam logic [ADDR_W-1:0] MID =
    ADDR_W'(COLUMN_SIZE / 2);
  localparam logic signed [PW-1:0] MAX_X =
    PW'(2**(DATA_W-1) - 1);
  localparam logic signed [PW-1:0] MIN_X = ~MAX_X;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PRIME, S_RD,
    S_WAIT, S_CALC, S_WR
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] idx;
  logic [1:0]        pcnt;
  logic [3:0]        eta_q;
  logic signed [DATA_W-1:0] rho_q;
  logic signed [DATA_W-1:0] up_q, ctr_q;
  logic signed [DATA_W-1:0] dn_q, pv_q;

  logic [DATA_W-1:0] u_mem [2**ADDR_W];
  logic [DATA_W-1:0] p_mem [2**ADDR_W];
  logic [DATA_W-1:0] u_rdata, p_rdata;
  logic [DATA_W-1:0] u_wdata, p_wdata;
  logic [ADDR_W-1:0] u_raddr;
  logic              mem_we;

  logic [DATA_W-1:0] k, init_val;

  logic signed [PW-1:0] up_x, dn_x, ctr_x, pv_x;
  logic signed [PW-1:0] rho_x, lap, vel, damp;
  logic signed [PW-1:0] prod, sum;
  logic signed [DATA_W-1:0] nxt;

  // Pyramid rises to the middle, falls to 0 at N-2,
  // and the clamped last node is 0.
  always_comb begin
    k = '0;
    if (idx < MID)
      k = DATA_W'(idx);
    else if (idx < LAST)
      k = DATA_W'(TOP - idx);
    init_val = k * INIT_STEP;
  end

  assign mem_we  = (state == S_INIT && busy) ||
                   state == S_WR;
  assign u_wdata = (state == S_INIT) ?
                   init_val : out_data;
  assign p_wdata = (state == S_INIT) ?
                   init_val : ctr_q;
  assign u_raddr = (state == S_PRIME) ?
                   '0 : idx + ADDR_W'(1);

  always_ff @(posedge clk_50) begin
    if (mem_we) begin
      u_mem[idx] <= u_wdata;
      p_mem[idx] <= p_wdata;
    end
    u_rdata <= u_mem[u_raddr];
    p_rdata <= p_mem[idx];
  end

  always_comb begin
    up_x  = PW'(up_q);
    dn_x  = PW'(dn_q);
    ctr_x = PW'(ctr_q);
    pv_x  = PW'(pv_q);
    rho_x = PW'(rho_q);
    lap   = up_x + dn_x - (ctr_x <<< 1);
    vel   = ctr_x - pv_x;
    damp  = vel >>> eta_q;
    prod  = rho_x * lap;
    sum   = ctr_x + vel - damp +
            (prod >>> (DATA_W-1));
    if (idx == LAST)
      nxt = '0;
    else if (sum > MAX_X)
      nxt = MAX_X[DATA_W-1:0];
    else if (sum < MIN_X)
      nxt = MIN_X[DATA_W-1:0];
    else
      nxt = sum[DATA_W-1:0];
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset)
      state <= S_INIT;
    else
      state <= state_d;
  end

  // After reset, INIT spends one cycle raising busy
  // before its first write.
  always_comb begin
    state_d = state;
    unique case (state)
      S_INIT:
        if (busy && idx == LAST) state_d = S_IDLE;
      S_IDLE:
        if (init)       state_d = S_INIT;
        else if (start) state_d = S_PRIME;
      S_PRIME:
        if (pcnt == 2'd2) state_d = S_RD;
      S_RD:   state_d = S_WAIT;
      S_WAIT: state_d = S_CALC;
      S_CALC: state_d = S_WR;
      S_WR:
        state_d = (idx == LAST) ? S_IDLE : S_RD;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      pcnt        <= '0;
      eta_q       <= '0;
      rho_q       <= '0;
      up_q        <= '0;
      ctr_q       <= '0;
      dn_q        <= '0;
      pv_q        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_data    <= '0;
      center_node <= '0;
    end else begin
      busy      <= (state_d != S_IDLE);
      done      <= (state == S_WR) && (idx == LAST);
      out_valid <= 1'b0;
      unique case (state)
        S_INIT:
          if (busy) idx <= idx + ADDR_W'(1);
        S_IDLE: begin
          idx  <= '0;
          pcnt <= '0;
          if (start && !init) begin
            rho_q <= rho;
            eta_q <= eta_shift;
          end
        end
        S_PRIME: begin
          pcnt <= pcnt + 2'd1;
          dn_q <= '0;
          if (pcnt == 2'd2) ctr_q <= u_rdata;
        end
        S_RD: ;
        S_WAIT: begin
          up_q <= (idx == LAST) ? '0 : u_rdata;
          pv_q <= p_rdata;
        end
        S_CALC: begin
          out_valid <= 1'b1;
          out_idx   <= idx;
          out_data  <= nxt;
          if (idx == MID) center_node <= nxt;
        end
        S_WR: begin
          dn_q  <= ctr_q;
          ctr_q <= up_q;
          idx   <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_column_engine.sv
// tb_drum_column_engine: directed + random steps checked against
// an array-based model of the column update rule.
module tb_drum_column_engine;

  localparam int N = 30;

  logic        clk_50 = 1'b0;
  logic        reset = 1'b0;
  logic        init = 1'b0;
  logic        start = 1'b0;
  logic [17:0] rho = '0;
  logic [3:0]  eta_shift = '0;
  logic        busy, done, out_valid;
  logic [8:0]  out_idx;
  logic [17:0] out_data, center_node;

  int tests = 0;
  int fails = 0;
  int nvalid = 0;
  int ndone = 0;
  longint got [N];
  longint mu [N];
  longint mp [N];

  drum_column_engine #(
    .DATA_W(18),
    .ADDR_W(9),
    .COLUMN_SIZE(N),
    .INIT_STEP(18'h01111)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .init(init),
    .start(start),
    .rho(rho),
    .eta_shift(eta_shift),
    .busy(busy),
    .done(done),
    .out_valid(out_valid),
    .out_idx(out_idx),
    .out_data(out_data),
    .center_node(center_node)
  );

  always #5 clk_50 = ~clk_50;

  always @(negedge clk_50) begin
    if (out_valid) begin
      nvalid++;
      if (out_idx < 9'(N))
        got[out_idx] = longint'($signed(out_data));
    end
    if (done) ndone++;
  end

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < N; i++) begin
      if (i < N/2)       mu[i] = i * 4369;
      else if (i < N-1)  mu[i] = (N-2-i) * 4369;
      else               mu[i] = 0;
      mp[i] = mu[i];
    end
  endtask

  task automatic model_step(input longint r,
                            input int e);
    longint nu [N];
    longint np [N];
    longint c, up, dn, lap, vel, v;
    for (int i = 0; i < N; i++) begin
      c   = mu[i];
      up  = (i < N-1) ? mu[i+1] : 0;
      dn  = (i > 0) ? mu[i-1] : 0;
      lap = up + dn - 2*c;
      vel = c - mp[i];
      v   = c + vel - (vel >>> e) +
            ((r * lap) >>> 17);
      if (v > 131071)  v = 131071;
      if (v < -131072) v = -131072;
      if (i == N-1)    v = 0;
      nu[i] = v;
      np[i] = c;
    end
    mu = nu;
    mp = np;
  endtask

  task automatic wait_init(input string tag);
    int cnt = 0;
    nvalid = 0;
    ndone = 0;
    for (int k = 0; k < 200; k++) begin
      if (busy) cnt++;
      else if (cnt > 0) break;
      @(posedge clk_50); #1;
    end
    chk({tag, "_busy"}, cnt, N);
    chk({tag, "_valid"}, nvalid, 0);
    chk({tag, "_done"}, ndone, 0);
  endtask

  task automatic do_step(input logic [17:0] r,
                         input int e,
                         input bit extra);
    int cyc;
    int bz_low;
    for (int i = 0; i < N; i++)
      got[i] = 1000000000;
    nvalid = 0;
    ndone = 0;
    bz_low = 0;
    @(negedge clk_50);
    rho = r;
    eta_shift = 4'(e);
    start = 1'b1;
    @(posedge clk_50); #1;
    start = 1'b0;
    rho = 18'($urandom);
    eta_shift = 4'($urandom);
    cyc = 1;
    while (!done && cyc < 1000) begin
      if (!busy) bz_low++;
      start = extra && (cyc == 10 || cyc == 50);
      init  = extra && (cyc == 30);
      @(posedge clk_50); #1;
      cyc++;
    end
    start = 1'b0;
    init = 1'b0;
    chk("latency", cyc, 4*N + 4);
    chk("busy_during", bz_low, 0);
    chk("busy_at_done", busy, 0);
    @(negedge clk_50);
    @(negedge clk_50);
    chk("nvalid", nvalid, N);
    chk("ndone", ndone, 1);
    model_step(longint'($signed(r)), e);
    for (int i = 0; i < N; i++)
      chk($sformatf("node%0d", i), got[i], mu[i]);
    chk("center",
        longint'($signed(center_node)), mu[N/2]);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk_50);
    #1;
    chk("reset_outs",
        {busy, done, out_valid, out_idx,
         out_data, center_node}, 0);
    @(negedge clk_50);
    reset = 1'b1;
    wait_init("por");
    model_init();

    do_step(18'h00000, 15, 1'b0);
    chk("pyr5", got[5], 'h05555);
    chk("pyr14", got[14], 'h0EEEE);
    chk("pyr15", got[15], 'h0DDDD);
    chk("pyr20", got[20], 'h08888);
    chk("pyr29", got[29], 0);
    chk("pyr_center",
        longint'($signed(center_node)), 'h0DDDD);

    do_step(18'h02000, 4, 1'b0);
    chk("flat1", got[1], 'h01111);

    for (int s = 0; s < 6; s++)
      do_step(18'($urandom),
              $urandom_range(0, 15), s == 2);
    for (int s = 0; s < 4; s++)
      do_step(18'h20000, 0, 1'b0);
    for (int s = 0; s < 3; s++)
      do_step(18'h1FFFF, $urandom_range(0, 3), 1'b0);

    @(negedge clk_50);
    init = 1'b1;
    start = 1'b1;
    rho = 18'h01234;
    @(posedge clk_50); #1;
    init = 1'b0;
    start = 1'b0;
    wait_init("init_start");
    model_init();
    do_step(18'h00000, 15, 1'b0);
    chk("reload14", got[14], 'h0EEEE);

    @(negedge clk_50);
    rho = '0;
    eta_shift = 4'd15;
    start = 1'b1;
    @(posedge clk_50); #1;
    start = 1'b0;
    repeat (40) @(posedge clk_50);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset",
        {busy, done, out_valid, out_idx,
         out_data, center_node}, 0);
    @(negedge clk_50);
    @(negedge clk_50);
    reset = 1'b1;
    wait_init("rst");
    model_init();
    do_step(18'h00000, 15, 1'b0);
    chk("rst_pyr14", got[14], 'h0EEEE);
    chk("rst_pyr5", got[5], 'h05555);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
